// File: rtl/sys_ctrl.sv
// sys_ctrl: sequencing controller in front of a weight-stationary
// SYS_ROW x SYS_COL systolic array (sys_array).
// When a job starts, the controller loads one weight matrix row by row. It then
// streams num_vec activation vectors into the array with a diagonal skew per lane.
// Finally it de-skews the column partial sums back into whole result vectors.
//
// Ports:
//   clk, rstn                     clock, async active-low reset
//   start, num_vec                job request (accepted in IDLE only), vector count
//   busy, done                    high outside IDLE / one-cycle end-of-job pulse
//   w_valid, w_ready, w_row       weight row handshake (bottom row first)
//   x_valid, x_ready, x_vec       activation vector handshake
//   arr_en, arr_w_wen, arr_w_in   array enable / weight write strobe / weight row
//   arr_in                        skewed activation lanes into the array
//   arr_psum, arr_en_out          column partial sums and per-column valids
//   res_valid, res_vec            de-skewed result vector, no backpressure
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_W  | accepting SYS_ROW weight rows
// STREAM  | accepting num_vec activation vectors
// DRAIN   | flushing the skew lanes, then waiting for all results
// DONE    | one-cycle done pulse
module sys_ctrl #(
  parameter int SYS_ROW    = 4,
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [CNT_WIDTH-1:0]            num_vec,
  output logic                            busy,
  output logic                            done,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [SYS_COL*DATA_WIDTH-1:0]   w_row,
  input  logic                            x_valid,
  output logic                            x_ready,
  input  logic [SYS_ROW*DATA_WIDTH-1:0]   x_vec,
  output logic                            arr_en,
  output logic [SYS_COL-1:0]              arr_w_wen,
  output logic [SYS_COL*DATA_WIDTH-1:0]   arr_w_in,
  output logic [SYS_ROW*DATA_WIDTH-1:0]   arr_in,
  input  logic [SYS_COL*2*DATA_WIDTH-1:0] arr_psum,
  input  logic [SYS_COL-1:0]              arr_en_out,
  output logic                            res_valid,
  output logic [SYS_COL*2*DATA_WIDTH-1:0] res_vec
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = $clog2(SYS_ROW + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_W, ST_STREAM, ST_DRAIN, ST_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    num_vec_q, x_left, res_cnt;
  logic [RW-1:0]           w_left, drain_cnt;
  logic                    w_acc, x_acc, advance;
  logic [SYS_COL*PW-1:0]   psum_aligned;

  // Only the last column's valid marks a whole aligned result vector.
  logic unused_en_out;
  assign unused_en_out = ^arr_en_out[SYS_COL-2:0];

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign w_ready = (state == ST_LOAD_W);
  assign x_ready = (state == ST_STREAM);

  always_comb begin
    state_nxt = state;
    w_acc     = 1'b0;
    x_acc     = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD_W;
      ST_LOAD_W: begin
        w_acc = w_valid;
        if (w_valid && w_left == RW'(1))
          state_nxt = (num_vec_q == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        x_acc   = x_valid;
        advance = x_valid;
        if (x_valid && x_left == CNT_WIDTH'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        advance = (drain_cnt != '0);
        if (drain_cnt == '0 && res_cnt == num_vec_q) state_nxt = ST_DONE;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      num_vec_q <= '0;
      x_left    <= '0;
      res_cnt   <= '0;
      w_left    <= '0;
      drain_cnt <= '0;
      arr_en    <= 1'b0;
      arr_w_wen <= '0;
      arr_w_in  <= '0;
      res_valid <= 1'b0;
      res_vec   <= '0;
    end else begin
      state     <= state_nxt;
      arr_en    <= advance;
      arr_w_wen <= {SYS_COL{w_acc}};
      if (w_acc) arr_w_in <= w_row;
      res_valid <= arr_en_out[SYS_COL-1];
      res_vec   <= psum_aligned;

      if (state == ST_IDLE && start) begin
        num_vec_q <= num_vec;
        x_left    <= num_vec;
        w_left    <= RW'(SYS_ROW);
      end else begin
        if (w_acc) w_left <= w_left - RW'(1);
        if (x_acc) x_left <= x_left - CNT_WIDTH'(1);
      end

      // Flush timer: SYS_ROW-1 zero-fill cycles push the last vector's upper lanes in.
      if (x_acc && x_left == CNT_WIDTH'(1))
        drain_cnt <= RW'(SYS_ROW - 1);
      else if (state == ST_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - RW'(1);

      if (state == ST_IDLE && start)
        res_cnt <= '0;
      else if (res_valid)
        res_cnt <= res_cnt + CNT_WIDTH'(1);
    end
  end

  // Input skew: lane r sees r shift stages plus the arr_in register.
  // All stages advance only on an accept or a flush cycle, so a stall freezes the diagonal.
  for (genvar r = 0; r < SYS_ROW; r++) begin : g_lane
    logic [DW-1:0] lane_in, lane_q;
    assign lane_in = (state == ST_STREAM) ? x_vec[r*DW +: DW] : '0;
    assign arr_in[r*DW +: DW] = lane_q;
    if (r == 0) begin : g_direct
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        lane_q <= '0;
        else if (advance) lane_q <= lane_in;
      end
    end else begin : g_shift
      logic [DW-1:0] sr [r];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
          lane_q <= '0;
        end else if (advance) begin
          sr[0] <= lane_in;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
          lane_q <= sr[r-1];
        end
      end
    end
  end

  // Output de-skew: column c leaves the array c cycles after column 0.
  // Delaying it by SYS_COL-1-c lines every column up with the last one.
  // These stages run every cycle because the array drains on its own.
  for (genvar c = 0; c < SYS_COL; c++) begin : g_col
    localparam int D = SYS_COL - 1 - c;
    if (D == 0) begin : g_direct
      assign psum_aligned[c*PW +: PW] = arr_psum[c*PW +: PW];
    end else begin : g_delay
      logic [PW-1:0] sr [D];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= arr_psum[c*PW +: PW];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign psum_aligned[c*PW +: PW] = sr[D-1];
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
module tb_sys_ctrl;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            rstn, start, busy, done;
  logic [CW-1:0]   num_vec;
  logic            w_valid, w_ready, x_valid, x_ready;
  logic [C*DW-1:0] w_row;
  logic [R*DW-1:0] x_vec;
  logic            arr_en, res_valid;
  logic [C-1:0]    arr_w_wen, arr_en_out;
  logic [C*DW-1:0] arr_w_in;
  logic [R*DW-1:0] arr_in;
  logic [C*PW-1:0] arr_psum, res_vec;

  sys_ctrl #(.SYS_ROW(R), .SYS_COL(C), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .x_valid(x_valid), .x_ready(x_ready), .x_vec(x_vec),
    .arr_en(arr_en), .arr_w_wen(arr_w_wen), .arr_w_in(arr_w_in), .arr_in(arr_in),
    .arr_psum(arr_psum), .arr_en_out(arr_en_out),
    .res_valid(res_valid), .res_vec(res_vec)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [C*DW-1:0] mkx(input int a0, input int a1, input int a2, input int a3);
    return {a3[DW-1:0], a2[DW-1:0], a1[DW-1:0], a0[DW-1:0]};
  endfunction

  function automatic logic [C*PW-1:0] mkr(input int a0, input int a1, input int a2, input int a3);
    return {a3[PW-1:0], a2[PW-1:0], a1[PW-1:0], a0[PW-1:0]};
  endfunction

  // ---------------- behavioural sys_array ----------------
  // Weights shift down on each w_wen. The input side advances only on en:
  // the n-th enabled cycle carries lane r of vector n-r. Once a vector's last
  // lane is in, its column sums leave the array column-staggered (column c
  // comes c cycles after column 0), free-running.
  logic [DW-1:0]   wt  [R][C];
  logic [DW-1:0]   act [64][R];
  bit              pv  [C];
  logic [C*PW-1:0] ps  [C];
  int              en_n;

  initial begin
    logic [PW-1:0] acc;
    int j;
    arr_psum = '0;
    arr_en_out = '0;
    en_n = 0;
    for (int c = 0; c < C; c++) begin pv[c] = 0; ps[c] = '0; end
    forever begin
      @(negedge clk); #2;
      if (!rstn) begin
        for (int c = 0; c < C; c++) pv[c] = 0;
        en_n = 0;
      end else begin
        for (int c = C - 1; c > 0; c--) begin pv[c] = pv[c-1]; ps[c] = ps[c-1]; end
        pv[0] = 0;
        if (arr_w_wen != '0) begin
          for (int r = R - 1; r > 0; r--) for (int c = 0; c < C; c++) wt[r][c] = wt[r-1][c];
          for (int c = 0; c < C; c++) wt[0][c] = arr_w_in[c*DW +: DW];
          en_n = 0;
        end
        if (arr_en) begin
          for (int r = 0; r < R; r++) begin
            j = en_n - r;
            if (j >= 0 && j < 64) act[j][r] = arr_in[r*DW +: DW];
          end
          if (en_n >= R - 1 && en_n - (R - 1) < 64) begin
            j = en_n - (R - 1);
            for (int c = 0; c < C; c++) begin
              acc = '0;
              for (int r = 0; r < R; r++) acc = acc + {16'b0, act[j][r]} * {16'b0, wt[r][c]};
              ps[0][c*PW +: PW] = acc;
            end
            pv[0] = 1;
          end
          en_n++;
        end
      end
      for (int c = 0; c < C; c++) begin
        arr_en_out[c] = pv[c];
        arr_psum[c*PW +: PW] = ps[c][c*PW +: PW];
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct { int due; logic [DW-1:0] v; } lat_t;
  logic [C*PW-1:0] sb [$];
  lat_t            lat_q [$];
  int nc = 0, done_cnt = 0, wen_cyc = 0, acc_cnt = 0, xr_cyc = 0;
  bit prev_done = 0;
  bit lat_chk = 0;

  initial begin
    forever begin
      @(negedge clk); #1;
      nc++;
      if (prev_done) chk("busy_after_done", busy, 0);
      prev_done = done;
      if (done) done_cnt++;
      if (arr_w_wen != '0) begin
        wen_cyc++;
        chk("w_wen_value", arr_w_wen, 4'hF);
      end
      if (x_ready) xr_cyc++;
      if (lat_q.size() > 0 && lat_q[0].due == nc) begin
        chk("lane3_latency", arr_in[3*DW +: DW], lat_q[0].v);
        void'(lat_q.pop_front());
      end
      if (x_valid && x_ready) begin
        acc_cnt++;
        if (lat_chk) lat_q.push_back('{nc + 4, x_vec[3*DW +: DW]});
      end
      if (res_valid) begin
        if (sb.size() == 0) chk("unexpected_result", res_vec, 0);
        else chk("result_vec", res_vec, sb.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [C*DW-1:0] wrow;
  logic [R*DW-1:0] xv [8];
  logic [C*PW-1:0] ex [8];

  task automatic send_w(input logic [C*DW-1:0] row);
    bit acc;
    int t = 0;
    w_valid = 1'b1;
    w_row = row;
    do begin acc = w_ready; @(negedge clk); t++; end while (!acc && t < 50);
    w_valid = 1'b0;
    chk("w_accepted", acc, 1);
  endtask

  task automatic send_x(input logic [R*DW-1:0] v);
    bit acc;
    int t = 0;
    x_valid = 1'b1;
    x_vec = v;
    do begin acc = x_ready; @(negedge clk); t++; end while (!acc && t < 50);
    x_valid = 1'b0;
    chk("x_accepted", acc, 1);
  endtask

  task automatic run_job(input int nv, input bit stall, input bit pulses);
    int d0, w0, a0, x0, t;
    d0 = done_cnt; w0 = wen_cyc; a0 = acc_cnt; x0 = xr_cyc;
    for (int k = 0; k < nv; k++) sb.push_back(ex[k]);
    start = 1'b1;
    num_vec = nv[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    num_vec = 8'hA5;
    for (int r = 0; r < R; r++) begin
      if (pulses && r == 1) begin
        start = 1'b1; num_vec = 8'd5; @(negedge clk); start = 1'b0;
      end
      send_w(wrow);
    end
    for (int k = 0; k < nv; k++) begin
      send_x(xv[k]);
      if (stall && k == 0) begin
        chk("en_after_accept", arr_en, 1);
        @(negedge clk); chk("en_stall0", arr_en, 0);
        @(negedge clk); chk("en_stall1", arr_en, 0);
      end
    end
    if (pulses && nv > 0) begin
      chk("busy_in_drain", busy, 1);
      start = 1'b1; num_vec = 8'd7; @(negedge clk); start = 1'b0;
    end
    t = 0;
    while (!done && t < 400) begin @(negedge clk); t++; end
    chk("done_seen", done, 1);
    repeat (12) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("w_wen_cycles", wen_cyc - w0, 4);
    if (nv == 0) chk("x_ready_cycles", xr_cyc - x0, 0);
    else chk("x_accepts", acc_cnt - a0, nv);
    chk("results_left", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int d0;
    rstn = 1'b0; start = 1'b0; num_vec = '0;
    w_valid = 1'b0; w_row = '0; x_valid = 1'b0; x_vec = '0;
    wrow = mkx(1, 2, 3, 4);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", {w_ready, x_ready}, 0);
    chk("rst_arr_en", arr_en, 0);
    chk("rst_wen", arr_w_wen, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_arr_in", arr_in, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single vector
    xv[0] = mkx(1, 2, 3, 4); ex[0] = mkr(10, 20, 30, 40);
    run_job(1, 0, 0);

    // 2: three back-to-back vectors, lane 3 skew latency
    xv[1] = mkx(0, 0, 0, 1); ex[1] = mkr(1, 2, 3, 4);
    xv[2] = mkx(2, 2, 2, 2); ex[2] = mkr(8, 16, 24, 32);
    lat_chk = 1;
    run_job(3, 0, 0);
    lat_chk = 0;
    repeat (2) @(negedge clk);
    chk("lane3_checks_left", lat_q.size(), 0);

    // 3: same with a 2-cycle stall after the first vector
    run_job(3, 1, 0);

    // 4: zero vectors
    run_job(0, 0, 0);

    // 5: reset in the middle of STREAM
    d0 = done_cnt;
    start = 1'b1; num_vec = 8'd3; @(negedge clk); start = 1'b0;
    for (int r = 0; r < R; r++) send_w(wrow);
    send_x(xv[0]);
    chk("pre_abort_en", arr_en, 1);
    rstn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_x_ready", x_ready, 0);
    chk("abort_arr_en", arr_en, 0);
    chk("abort_arr_in", arr_in, 0);
    chk("abort_arr_w_in", arr_w_in, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_job(1, 0, 0);

    // 6: start pulses in LOAD_W and DRAIN are ignored
    xv[1] = mkx(2, 2, 2, 2); ex[1] = mkr(8, 16, 24, 32);
    run_job(2, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
